// File: rtl/rvvi_pkg.sv
// rvvi_pkg: beat tags, FSM states and packet field offsets shared by RVVI trace producer and consumer
package rvvi_pkg;
  typedef enum logic [2:0] {TAG_PC, TAG_INSTR, TAG_MCYCLE, TAG_MINSTRET, TAG_GPR, TAG_FPR, TAG_CSR} beat_tag_t;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_GPR, S_FPR, S_CSR} state_t;
  localparam int OFS_INSTR    = 0;
  localparam int OFS_MCYCLE   = 32;
  localparam int OFS_MINSTRET = 96;
  localparam int OFS_TRAP     = 160;
  localparam int OFS_PRIV     = 161;
  localparam int OFS_GPRWEN   = 163;
  localparam int OFS_FPRWEN   = 164;
  localparam int OFS_CSRCNT   = 168;
  function automatic int req_w(input int xlen);
    return 56 + 3 * xlen;
  endfunction
  function automatic int pkt_w(input int xlen, input int max_csrs);
    return req_w(xlen) + 16 + 2 * xlen + max_csrs * (xlen + 16);
  endfunction
endpackage

// File: rtl/rvvi_pkt_fields.sv
// rvvi_pkt_fields: slices a held RVVI packet into named header, register and CSR slot fields
module rvvi_pkt_fields import rvvi_pkg::*; #(
  parameter int XLEN     = 64,
  parameter int MAX_CSRS = 5
) (
  input  logic [pkt_w(XLEN, MAX_CSRS)-1:0]  pkt_i,
  output logic [XLEN-1:0]                   pc_o,
  output logic [31:0]                       instr_o,
  output logic [63:0]                       mcycle_o,
  output logic [63:0]                       minstret_o,
  output logic                              trap_o,
  output logic [1:0]                        priv_o,
  output logic                              gpr_wen_o,
  output logic                              fpr_wen_o,
  output logic [11:0]                       csr_cnt_o,
  output logic [4:0]                        gpr_addr_o,
  output logic [XLEN-1:0]                   gpr_val_o,
  output logic [4:0]                        fpr_addr_o,
  output logic [XLEN-1:0]                   fpr_val_o,
  output logic [MAX_CSRS-1:0][11:0]         csr_addr_o,
  output logic [MAX_CSRS-1:0][XLEN-1:0]     csr_val_o
);
  localparam int RW = req_w(XLEN);
  assign pc_o       = pkt_i[XLEN-1:0];
  assign instr_o    = pkt_i[XLEN+OFS_INSTR +: 32];
  assign mcycle_o   = pkt_i[XLEN+OFS_MCYCLE +: 64];
  assign minstret_o = pkt_i[XLEN+OFS_MINSTRET +: 64];
  assign trap_o     = pkt_i[XLEN+OFS_TRAP];
  assign priv_o     = pkt_i[XLEN+OFS_PRIV +: 2];
  assign gpr_wen_o  = pkt_i[XLEN+OFS_GPRWEN];
  assign fpr_wen_o  = pkt_i[XLEN+OFS_FPRWEN];
  assign csr_cnt_o  = pkt_i[XLEN+OFS_CSRCNT +: 12];
  assign gpr_addr_o = pkt_i[RW +: 5];
  assign gpr_val_o  = pkt_i[RW+8 +: XLEN];
  assign fpr_addr_o = pkt_i[RW+XLEN+8 +: 5];
  assign fpr_val_o  = pkt_i[RW+XLEN+16 +: XLEN];
  for (genvar i = 0; i < MAX_CSRS; i++) begin : g_slot
    localparam int BASE = RW + 16 + 2 * XLEN + i * (XLEN + 16);
    assign csr_addr_o[i] = pkt_i[BASE +: 12];
    assign csr_val_o[i]  = pkt_i[BASE+16 +: XLEN];
    logic unused_pad;
    assign unused_pad = ^pkt_i[BASE+12 +: 4];
  end
  logic unused_hdr_pad;
  assign unused_hdr_pad = ^{pkt_i[XLEN+OFS_FPRWEN+1 +: 3], pkt_i[XLEN+OFS_CSRCNT+12 +: RW-XLEN-OFS_CSRCNT-12],
                            pkt_i[RW+5 +: 3], pkt_i[RW+XLEN+13 +: 3]};
endmodule

// File: rtl/rvvi_beat_serializer.sv
// rvvi_beat_serializer: captures RVVI trace packets and streams them out as tag/addr/data beats
module rvvi_beat_serializer import rvvi_pkg::*; #(
  parameter int XLEN     = 64,
  parameter int MAX_CSRS = 5,
  parameter int DROP_W   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid,
  input  logic [pkt_w(XLEN, MAX_CSRS)-1:0] rvvi,
  output logic                             BeatValid,
  input  logic                             BeatReady,
  output beat_tag_t                        BeatTag,
  output logic [11:0]                      BeatAddr,
  output logic [63:0]                      BeatData,
  output logic                             BeatLast,
  output logic                             Busy,
  output logic [DROP_W-1:0]                DropCount,
  output logic                             CountErr
);
  localparam int PW = pkt_w(XLEN, MAX_CSRS);
  localparam int CW = $clog2(MAX_CSRS + 1);
  if (XLEN != 64) begin : g_bad_xlen
    $error("rvvi_beat_serializer supports XLEN=64 only");
  end
  state_t state_q, state_d;
  logic [1:0] hdr_q, hdr_d;
  logic [CW-1:0] idx_q, idx_d, n_csr;
  logic [PW-1:0] pkt_q, pkt_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic err_q, err_d, valid_q, valid_d, last_q, last_d, fire, last_fire, cap;
  beat_tag_t tag_q, tag_d;
  logic [11:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [XLEN-1:0] pc, gpr_val, fpr_val;
  logic [31:0] instr;
  logic [63:0] mcycle, minstret;
  logic trap, gpr_wen, fpr_wen;
  logic [1:0] priv;
  logic [11:0] csr_cnt;
  logic [4:0] gpr_addr, fpr_addr;
  logic [MAX_CSRS-1:0][11:0] csr_addr;
  logic [MAX_CSRS-1:0][XLEN-1:0] csr_val;
  // Fields are sliced from the next packet so a freshly captured packet drives its first beat directly.
  rvvi_pkt_fields #(.XLEN(XLEN), .MAX_CSRS(MAX_CSRS)) u_fields (
    .pkt_i(pkt_d), .pc_o(pc), .instr_o(instr), .mcycle_o(mcycle), .minstret_o(minstret),
    .trap_o(trap), .priv_o(priv), .gpr_wen_o(gpr_wen), .fpr_wen_o(fpr_wen), .csr_cnt_o(csr_cnt),
    .gpr_addr_o(gpr_addr), .gpr_val_o(gpr_val), .fpr_addr_o(fpr_addr), .fpr_val_o(fpr_val),
    .csr_addr_o(csr_addr), .csr_val_o(csr_val)
  );
  assign fire      = valid_q & BeatReady;
  assign last_fire = fire & last_q;
  assign Busy      = (state_q != S_IDLE) & ~last_fire;
  assign cap       = valid & ~Busy;
  assign n_csr     = (csr_cnt > 12'(MAX_CSRS)) ? CW'(MAX_CSRS) : csr_cnt[CW-1:0];
  // Capture/drop bookkeeping and FSM advance; BeatLast already marks the end so no emptiness tests are needed here.
  always_comb begin
    pkt_d   = cap ? rvvi : pkt_q;
    drop_d  = (valid & Busy & ~&drop_q) ? drop_q + DROP_W'(1) : drop_q;
    err_d   = err_q | (cap & (csr_cnt > 12'(MAX_CSRS)));
    state_d = state_q;
    hdr_d   = hdr_q;
    idx_d   = idx_q;
    if (cap) begin
      state_d = S_HDR;
      hdr_d   = '0;
      idx_d   = '0;
    end else if (last_fire) begin
      state_d = S_IDLE;
    end else if (fire) begin
      case (state_q)
        S_HDR: begin
          hdr_d = hdr_q + 2'd1;
          if (hdr_q == 2'd3) state_d = gpr_wen ? S_GPR : fpr_wen ? S_FPR : S_CSR;
        end
        S_GPR:   state_d = fpr_wen ? S_FPR : S_CSR;
        S_FPR:   state_d = S_CSR;
        S_CSR:   idx_d = idx_q + CW'(1);
        default: state_d = S_IDLE;
      endcase
    end
  end
  // Beat contents for the next state; unchanged while stalled, so outputs hold without an explicit enable.
  always_comb begin
    valid_d = state_d != S_IDLE;
    tag_d   = TAG_PC;
    addr_d  = '0;
    data_d  = '0;
    last_d  = 1'b0;
    case (state_d)
      S_HDR: begin
        tag_d  = beat_tag_t'({1'b0, hdr_d});
        addr_d = (hdr_d == 2'd0) ? {4'b0, csr_cnt[3:0], 1'b0, trap, priv} : '0;
        data_d = (hdr_d == 2'd0) ? pc : (hdr_d == 2'd1) ? {32'b0, instr} : (hdr_d == 2'd2) ? mcycle : minstret;
        last_d = (hdr_d == 2'd3) & ~gpr_wen & ~fpr_wen & (n_csr == '0);
      end
      S_GPR: begin
        tag_d  = TAG_GPR;
        addr_d = {7'b0, gpr_addr};
        data_d = gpr_val;
        last_d = ~fpr_wen & (n_csr == '0);
      end
      S_FPR: begin
        tag_d  = TAG_FPR;
        addr_d = {7'b0, fpr_addr};
        data_d = fpr_val;
        last_d = n_csr == '0;
      end
      S_CSR: begin
        tag_d  = TAG_CSR;
        addr_d = csr_addr[idx_d];
        data_d = csr_val[idx_d];
        last_d = idx_d == n_csr - CW'(1);
      end
      default: valid_d = 1'b0;
    endcase
  end
  // State, packet hold, counters and registered beat outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      idx_q   <= '0;
      pkt_q   <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      tag_q   <= TAG_PC;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end
  assign BeatValid = valid_q;
  assign BeatTag   = tag_q;
  assign BeatAddr  = addr_q;
  assign BeatData  = data_q;
  assign BeatLast  = last_q;
  assign DropCount = drop_q;
  assign CountErr  = err_q;
endmodule
